// File: rtl/mac_pkg.sv
// Shared constants, state type and helpers for the MAC requantizer.
// Contents:
//   MAC_IN_W / MAC_OUT_W / REQ_OUT_W - operand, MAC result and requantized widths
//   state_e                          - requantizer FSM state (ACCUM, HOLD)
//   min_acc_w()                      - smallest accumulator width that cannot overflow
package mac_pkg;

  localparam int unsigned MAC_IN_W  = 8;
  localparam int unsigned MAC_OUT_W = 16;
  localparam int unsigned REQ_OUT_W = 8;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Summing n_terms values of MAC_OUT_W bits grows the result by clog2(n_terms) bits.
  function automatic int unsigned min_acc_w(input int unsigned n_terms);
    return MAC_OUT_W + $clog2(n_terms);
  endfunction

endpackage

// File: rtl/mac_requant_if.sv
// Stream bundle between the MAC array and the requantizer output consumer.
// Signals:
//   in_valid/in_ready/in_data    - 16-bit unsigned MAC results, valid/ready
//   out_valid/out_ready          - requantized byte handshake
//   out_data/out_sat             - requantized byte and clamp flag
// Modports: master drives the input stream and accepts outputs; slave is the requantizer.
interface mac_requant_if;
  import mac_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [MAC_OUT_W-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [REQ_OUT_W-1:0] out_data;
  logic                 out_sat;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );

endinterface

// File: rtl/requant_sat.sv
// Combinational shift-and-saturate: floor(sum >> SHIFT) clamped to an unsigned byte.
// Ports:
//   sum - accumulated value (ACC_W bits, unsigned)
//   q   - requantized byte, 255 when clamped
//   sat - set when the shifted value exceeded 255
module requant_sat
  import mac_pkg::*;
#(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned SHIFT = 8
) (
  input  logic [ACC_W-1:0]     sum,
  output logic [REQ_OUT_W-1:0] q,
  output logic                 sat
);

  logic [ACC_W-1:0] shifted;

  always_comb begin
    shifted = sum >> SHIFT;
    sat     = shifted > ACC_W'(2 ** REQ_OUT_W - 1);
    q       = sat ? '1 : shifted[REQ_OUT_W-1:0];
  end

endmodule

// File: rtl/mac_requant.sv
// Requantizer: sums N_TERMS 16-bit MAC results, shifts right by SHIFT and saturates
// to an unsigned byte, holding the byte on a valid/ready output until taken.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - mac_requant_if.slave (input stream in, requantized byte out)
module mac_requant
  import mac_pkg::*;
#(
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned SHIFT   = 8,
  parameter int unsigned ACC_W   = 24
) (
  input  logic         clk,
  input  logic         rst,
  mac_requant_if.slave bus
);

  localparam int unsigned CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  if (N_TERMS < 1) begin : gen_bad_n_terms
    $error("mac_requant: N_TERMS must be at least 1");
  end
  if (ACC_W < min_acc_w(N_TERMS)) begin : gen_bad_acc_w
    $error("mac_requant: ACC_W too narrow for N_TERMS");
  end
  if (ACC_W <= SHIFT) begin : gen_bad_shift
    $error("mac_requant: ACC_W must exceed SHIFT");
  end

  state_e               state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [REQ_OUT_W-1:0] data_q, data_d;
  logic                 sat_q, sat_d;

  logic [ACC_W-1:0]     sum;
  logic [REQ_OUT_W-1:0] q;
  logic                 q_sat;
  logic                 in_ready, out_valid;
  logic                 in_fire, out_fire, last_term;

  assign sum       = acc_q + ACC_W'(bus.in_data);
  assign in_fire   = bus.in_valid & in_ready;
  assign out_fire  = out_valid & bus.out_ready;
  assign last_term = (cnt_q == LAST_CNT);

  // The final term goes straight from the adder into the output register, so the
  // byte is valid the cycle after the last input handshake.
  requant_sat #(
    .ACC_W(ACC_W),
    .SHIFT(SHIFT)
  ) u_requant_sat (
    .sum(sum),
    .q  (q),
    .sat(q_sat)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (in_fire && last_term) state_d = HOLD;
      HOLD:    if (out_fire) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Outputs. in_ready is masked by rst so nothing is accepted during the reset cycle.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACCUM:   in_ready = ~rst;
      HOLD:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath next state.
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    sat_d  = sat_q;
    if (in_fire) begin
      if (last_term) begin
        data_d = q;
        sat_d  = q_sat;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (out_fire) begin
      acc_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      sat_q  <= sat_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = data_q;
  assign bus.out_sat   = sat_q;

endmodule

// File: doc/mac_requant.md
Name: mac_requant

Overview:
- Consumer-side counterpart of the 8x8+8 MAC datapath. The MAC widens 8-bit operands to a 16-bit result; this block narrows results back to 8 bits.
- Accepts a stream of 16-bit MAC results over a valid/ready handshake.
- Accumulates N_TERMS results per output, right-shifts by SHIFT, saturates to 8 bits unsigned, and presents the byte on a valid/ready output.
- Sits between the MAC array and the next layer's 8-bit activation input.

Parameters:
- N_TERMS, 4, MAC results summed per output byte (>=1).
- SHIFT, 8, right-shift applied to the final sum (truncating, floor).
- ACC_W, 24, accumulator width. Must be >= 16 + clog2(N_TERMS) and > SHIFT.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  16  unsigned MAC result.
- out_valid  out  1  out_data/out_sat valid.
- out_ready  in  1  downstream accepts the output.
- out_data  out  8  requantized unsigned byte.
- out_sat  out  1  set when the shifted sum exceeded 255 and was clamped.

Behaviour:
- Arithmetic is unsigned throughout. The accumulator zero-extends in_data to ACC_W and cannot overflow under the ACC_W rule.
- State machine has two states, ACCUM and HOLD.
- Reset (rst=1 at a clock edge) sets:
  - state = ACCUM, acc = 0, cnt = 0.
  - out_valid = 0, out_data = 0, out_sat = 0.
  - in_ready is 0 during the reset cycle and 1 from the following cycle.
- ACCUM:
  - in_ready = 1, out_valid = 0.
  - On in_valid & in_ready with cnt < N_TERMS-1: acc += in_data, cnt += 1.
  - On in_valid & in_ready with cnt == N_TERMS-1:
    - sum = acc + in_data, s = sum >> SHIFT.
    - out_data <= (s > 255) ? 255 : s[7:0]; out_sat <= (s > 255).
    - state <= HOLD.
  - in_valid gaps stall accumulation with no loss and no spurious terms.
- HOLD:
  - in_ready = 0, out_valid = 1.
  - out_data and out_sat remain stable until the handshake.
  - On out_valid & out_ready: acc <= 0, cnt <= 0, state <= ACCUM. in_ready stays 0 in the handshake cycle itself.
- Latency: out_valid rises on the clock edge that accepts the last term, i.e. it is visible the cycle after the last in handshake.
- Peak throughput: one byte per N_TERMS+1 cycles.
- out_valid must never drop without a handshake unless rst is asserted.
- rst overrides everything, including mid-accumulation and HOLD. Partial sums and pending outputs are discarded.
- N_TERMS = 1: every accepted input produces an output directly.
- Boundary: sum >> SHIFT == 255 gives out_data = 255 with out_sat = 0; 256 gives 255 with out_sat = 1.
- in_data is ignored whenever in_ready = 0.

Decomposition:
- Package mac_pkg holds:
  - Constants: MAC_IN_W=8, MAC_OUT_W=16, REQ_OUT_W=8.
  - A function computing the minimum ACC_W, used for an elaboration-time check.
  - A 1-bit state enum: ACCUM, HOLD.
- One sub-module, requant_sat: combinational shift-and-saturate. Parameters ACC_W and SHIFT; input sum[ACC_W-1:0]; outputs q[7:0] and sat. It is instantiated once on the acc + in_data path.

Test Plan:
- Nominal (N_TERMS=4, SHIFT=8): in 0x0100, 0x0200, 0x0300, 0x0400 back-to-back with out_ready=1 -> out_data=10 (0x0A), out_sat=0, out_valid for 1 cycle, 5 cycles/result.
- Saturation: 4 x 0xFFFF (sum 0x3FFFC) -> out_data=255, out_sat=1.
- Saturation edge:
  - 0xFF00, 0, 0, 0 -> out_data=255, out_sat=0.
  - 0xFF00, 0x0100, 0, 0 -> out_data=255, out_sat=1.
- Backpressure and gaps:
  - in_valid toggled 1,0,1,0,... over 4 terms of 0x00FF -> out_data=3.
  - Then out_ready held 0 for 5 cycles -> out_valid=1, out_data stable at 3, in_ready=0 throughout; a 5th in_valid during this window is not consumed.
- Reset mid-operation:
  - After 2 terms of 0x8000, assert rst for 1 cycle -> out_valid=0, out_data=0, in_ready=1 the next cycle.
  - Then 4 x 0x0100 -> out_data=4, out_sat=0 (no residue from the discarded terms).
- N_TERMS=1, SHIFT=4: in 0x0FF0 -> out_data=255, out_sat=0; in 0x1000 -> out_data=255, out_sat=1; both 1 cycle after the handshake.
